ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter GATE_LOG2, default 16: gate window is 2^GATE_LOG2 clk cycles.
REQ-002 SHALL have parameter CNT_W, default 16: width of the edge count.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ro_in, input, 1: asynchronous divided ring-oscillator output under measurement.
REQ-007 SHALL have port en, input, 1: measurement enable.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-009 SHALL have port out_valid, output, 1: result held and pending.
REQ-010 SHALL have port out_count, output, CNT_W: rising edges counted in the last window.
REQ-011 SHALL have port out_sat, output, 1: count saturated.
REQ-012 SHALL have port out_overrun, output, 1: a previous unaccepted result was overwritten.
REQ-013 SHALL have ports out_min and out_max, output, CNT_W each: extremes of the completed counts.
REQ-014 SHALL have port busy, output, 1: high in states ARM, GATE and DONE.

Function
REQ-015 SHALL pass ro_in through SYNC_STAGES flops, then a rising-edge detector; one detected edge = one count.
REQ-016 SHALL count correctly whenever the high and low phases of ro_in each last at least 2 clk periods; faster inputs are undefined.
REQ-017 SHALL implement states IDLE, ARM, GATE and DONE.
REQ-018 SHALL move IDLE->ARM when en=1.
REQ-019 SHALL hold ARM for exactly SYNC_STAGES+1 cycles, counting nothing, then enter GATE with the edge and gate counters zeroed.
REQ-020 SHALL stay in GATE for exactly 2^GATE_LOG2 cycles, counting edges detected in each of those cycles, including the last, then enter DONE.
REQ-021 SHALL make the edge counter saturate at 2^CNT_W-1 and set a sticky sat bit for that window.
REQ-022 SHALL, in DONE (1 cycle, edges ignored), load out_count and out_sat and set out_valid on the next edge.
REQ-023 SHALL move DONE->GATE with counters zeroed if en=1, giving back-to-back windows with a 1-cycle gap; otherwise DONE->IDLE.
REQ-024 SHALL move to IDLE on the next edge if en=0 in ARM or GATE, discard the partial count and leave out_valid unchanged.
REQ-025 SHALL clear out_valid when out_valid=1 and out_ready=1; if a load occurs in the same cycle, the load wins and out_valid stays 1 with out_overrun=0.
REQ-026 SHALL set out_overrun=1 if a load occurs while out_valid=1 and out_ready=0; each load with no overrun writes 0.
REQ-027 SHALL hold out_count, out_sat and out_overrun stable while out_valid=1 until acceptance or the next load.

Reset
REQ-028 SHALL, on rst=1, set state IDLE and clear all counters, synchronizer flops, the edge detector, out_valid, out_count, out_sat, out_overrun and out_max, and set out_min to all-ones.
REQ-029 SHALL give rst priority over all other inputs, including mid-GATE, and produce no result from the aborted window.

Configuration
REQ-030 SHALL, with RO_FREQ_MINMAX_EN defined, update out_min and out_max on every load and re-initialize them to all-ones and 0 on each IDLE->ARM transition.
REQ-031 SHALL, without RO_FREQ_MINMAX_EN, keep the out_min and out_max ports and tie them to constant 0, with no min/max registers.

Structure
REQ-032 SHALL put the state enum type and the ARM-length constant SYNC_STAGES+1 in package ro_freq_pkg.
REQ-033 SHALL place the synchronizer and edge detector in sub-module ro_sync_edge (ports clk, rst, d, rise).

Verification (GATE_LOG2=4, CNT_W=16, SYNC_STAGES=2 unless stated)
REQ-034 SHALL cover: ro_in rising every 4 clk with en=1 and out_ready=1 -> out_valid pulses once per window; out_count=4, out_sat=0.
REQ-035 SHALL cover: CNT_W=2 and ro_in rising every 4 clk with GATE_LOG2=5 -> out_count=3, out_sat=1.
REQ-036 SHALL cover: out_ready=0 across two windows -> second result shown with out_overrun=1; after acceptance out_valid=0.
REQ-037 SHALL cover: en dropped 5 cycles into GATE -> busy=0 on the next cycle and no out_valid; rst asserted mid-GATE -> all outputs at reset values.
REQ-038 SHALL cover: with RO_FREQ_MINMAX_EN, windows with ro_in periods 4 then 8 clk -> out_max=4, out_min=2; without the macro both read 0.

Source files
------------

// File: rtl/ro_freq_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// The ARM length is one cycle longer than the synchronizer depth.
package ro_freq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int ARM_LEN_DEFAULT     = SYNC_STAGES_DEFAULT + 1;

  // ARM must outlast the synchronizer pipeline so no stale edge is counted.
  function automatic int arm_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// The output pulses for one clk cycle per synchronized low-to-high transition.
module ro_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated edge counter measuring a divided ring-oscillator against clk.
// Optional RO_FREQ_MINMAX_EN tracks the min/max count since the last arm.
module ro_freq_meter
  import ro_freq_pkg::*;
#(
  parameter int GATE_LOG2   = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_overrun,
  output logic [CNT_W-1:0] out_min,
  output logic [CNT_W-1:0] out_max,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int         ARM_LEN  = arm_len(SYNC_STAGES);
  localparam logic [2:0] ARM_LAST = 3'(ARM_LEN - 1);

  // Handshake: a result is transferred on a rising clk edge where
  // out_valid=1 and out_ready=1; out_count/out_sat/out_overrun stay
  // stable while out_valid=1 until that transfer or the next load.

  logic                 w_rise;
  logic                 w_load;

  state_t               r_state;
  logic [2:0]           r_arm_cnt;
  logic [GATE_LOG2-1:0] r_gate_cnt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;

  logic                 r_valid;
  logic [CNT_W-1:0]     r_count;
  logic                 r_out_sat;
  logic                 r_overrun;

  ro_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (ro_in),
    .rise (w_rise)
  );

  assign w_load = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_arm_cnt  <= '0;
      r_gate_cnt <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state   <= S_ARM;
            r_arm_cnt <= '0;
          end
        end
        S_ARM: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (r_arm_cnt == ARM_LAST) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
          end else begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
          end
        end
        S_GATE: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else begin
            // Saturating count; sat flags an edge that could not be counted.
            if (w_rise) begin
              if (r_cnt == {CNT_W{1'b1}}) r_sat <= 1'b1;
              else                        r_cnt <= r_cnt + CNT_W'(1);
            end
            r_gate_cnt <= r_gate_cnt + GATE_LOG2'(1);
            if (r_gate_cnt == {GATE_LOG2{1'b1}}) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (en) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A load beats a simultaneous acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_out_sat <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_count   <= r_cnt;
      r_out_sat <= r_sat;
      r_overrun <= r_valid & ~out_ready;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef RO_FREQ_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min <= '1;
      r_max <= '0;
    end else if (r_state == S_IDLE && en) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_load) begin
      if (r_cnt < r_min) r_min <= r_cnt;
      if (r_cnt > r_max) r_max <= r_cnt;
    end
  end

  assign out_min = r_min;
  assign out_max = r_max;
`else
  assign out_min = '0;
  assign out_max = '0;
`endif

  assign out_valid   = r_valid;
  assign out_count   = r_count;
  assign out_sat     = r_out_sat;
  assign out_overrun = r_overrun;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: vector table plus scoreboard and
// hand-written sequences for overrun, abort, reset and min/max behaviour.
module tb_ro_freq_meter;
  import ro_freq_pkg::*;

  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ro_in, en, out_ready;
  logic          out_valid, out_sat, out_overrun, busy;
  logic [CW-1:0] out_count, out_min, out_max;
  state_t        dbg_state;

  logic          en2, ready2;
  logic          out_valid2, out_sat2, out_overrun2, busy2;
  logic [1:0]    out_count2, out_min2, out_max2;
  state_t        dbg_state2;

  ro_freq_meter #(.GATE_LOG2(4), .CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .en(en), .out_ready(out_ready),
    .out_valid(out_valid), .out_count(out_count), .out_sat(out_sat),
    .out_overrun(out_overrun), .out_min(out_min), .out_max(out_max),
    .busy(busy), .dbg_state(dbg_state)
  );

  ro_freq_meter #(.GATE_LOG2(5), .CNT_W(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .en(en2), .out_ready(ready2),
    .out_valid(out_valid2), .out_count(out_count2), .out_sat(out_sat2),
    .out_overrun(out_overrun2), .out_min(out_min2), .out_max(out_max2),
    .busy(busy2), .dbg_state(dbg_state2)
  );

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input state_t s, input int bound, input string name);
    int k;
    k = 0;
    while (dbg_state !== s && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (dbg_state !== s) fail_now(name);
  endtask

  task automatic check_reset(input string tag);
    logic [CW-1:0] exp_min;
`ifdef RO_FREQ_MINMAX_EN
    exp_min = '1;
`else
    exp_min = '0;
`endif
    chk({tag, "_valid"},   32'(out_valid),   32'd0);
    chk({tag, "_count"},   32'(out_count),   32'd0);
    chk({tag, "_sat"},     32'(out_sat),     32'd0);
    chk({tag, "_overrun"}, 32'(out_overrun), 32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_state"},   32'(dbg_state),   32'(S_IDLE));
    chk({tag, "_min"},     32'(out_min),     32'(exp_min));
    chk({tag, "_max"},     32'(out_max),     32'd0);
  endtask

  // ---------------- ring-oscillator driver ----------------
  int ro_period = 0;
  int ph = 0;
  initial begin
    ro_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ro_period == 0) begin
        ro_in = 1'b0;
        ph    = 0;
      end else begin
        ph    = (ph + 1) % ro_period;
        ro_in = (ph < ro_period / 2);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [CW+1:0] exp_q[$];
  logic [CW+1:0] mon_e;
  bit            mon_en = 1'b0;
  logic          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (mon_en && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: got result %0h with no expected entry", out_count);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_count",   32'(out_count),   32'(mon_e[CW+1:2]));
        chk("sb_sat",     32'(out_sat),     32'(mon_e[1]));
        chk("sb_overrun", 32'(out_overrun), 32'(mon_e[0]));
      end
    end
    prev_valid = out_valid;
  end

  // ---------------- vectors ----------------
  typedef struct {
    int            period;
    logic [CW-1:0] exp_count;
    logic          exp_sat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int k;
    bit saw;

    vecs[0] = '{4,  16'd4, 1'b0};
    vecs[1] = '{8,  16'd2, 1'b0};
    vecs[2] = '{16, 16'd1, 1'b0};
    vecs[3] = '{0,  16'd0, 1'b0};

    rst = 1'b1; en = 1'b0; out_ready = 1'b1; en2 = 1'b0; ready2 = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check_reset("reset");

    // ARM/GATE timing, one-cycle DONE gap, then abort 5 cycles into GATE
    ro_period = 4;
    cyc(10);
    en = 1'b1;
    cyc(1);
    chk("arm_busy", 32'(busy), 32'd1);
    k = 0;
    while (dbg_state == S_ARM && k < 20) begin cyc(1); k++; end
    chk("arm_len", 32'(k), 32'd3);
    k = 0;
    while (dbg_state == S_GATE && k < 40) begin cyc(1); k++; end
    chk("gate_len", 32'(k), 32'd16);
    chk("done_state", 32'(dbg_state), 32'(S_DONE));
    cyc(1);
    chk("b2b_state",  32'(dbg_state), 32'(S_GATE));
    chk("load_valid", 32'(out_valid), 32'd1);
    chk("load_count", 32'(out_count), 32'd4);
    chk("load_sat",   32'(out_sat),   32'd0);
    cyc(1);
    chk("accept_valid", 32'(out_valid), 32'd0);
    cyc(3);
    en = 1'b0;
    cyc(1);
    chk("abort_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (40) begin cyc(1); if (out_valid) saw = 1'b1; end
    chk("abort_no_result", 32'(saw), 32'd0);

    // table: one window per vector through the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ro_period = vecs[i].period;
      cyc(20);
      exp_q.push_back({vecs[i].exp_count, vecs[i].exp_sat, 1'b0});
      en = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin cyc(1); k++; end
      if (exp_q.size() != 0) begin fail_now("vec_result"); exp_q.delete(); end
      en = 1'b0;
      cyc(5);
    end

    // three back-to-back windows, one valid pulse each
    ro_period = 4;
    cyc(10);
    for (int i = 0; i < 3; i++) exp_q.push_back({16'd4, 1'b0, 1'b0});
    en = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin cyc(1); k++; end
    if (exp_q.size() != 0) begin fail_now("b2b_results"); exp_q.delete(); end
    en = 1'b0;
    cyc(5);
    mon_en = 1'b0;

    // overrun: consumer stalled across two windows
    out_ready = 1'b0;
    en = 1'b1;
    wait_state(S_DONE, 60, "ovr_first_done");
    cyc(1);
    chk("ovr1_valid",   32'(out_valid),   32'd1);
    chk("ovr1_count",   32'(out_count),   32'd4);
    chk("ovr1_overrun", 32'(out_overrun), 32'd0);
    wait_state(S_DONE, 40, "ovr_second_done");
    cyc(1);
    chk("ovr2_valid",   32'(out_valid),   32'd1);
    chk("ovr2_count",   32'(out_count),   32'd4);
    chk("ovr2_overrun", 32'(out_overrun), 32'd1);
    en = 1'b0;
    cyc(2);
    chk("ovr_hold_valid",   32'(out_valid),   32'd1);
    chk("ovr_hold_overrun", 32'(out_overrun), 32'd1);
    out_ready = 1'b1;
    cyc(1);
    chk("ovr_accept_valid", 32'(out_valid), 32'd0);

    // reset in the middle of a window
    en = 1'b1;
    wait_state(S_GATE, 20, "rst_gate");
    cyc(6);
    rst = 1'b1;
    en  = 1'b0;
    cyc(1);
    rst = 1'b0;
    check_reset("midgate_rst");
    saw = 1'b0;
    repeat (30) begin cyc(1); if (out_valid) saw = 1'b1; end
    chk("rst_no_result", 32'(saw), 32'd0);

    // min/max across windows of period 4 then 8
    ro_period = 4;
    cyc(10);
    en = 1'b1;
    wait_state(S_DONE, 60, "mm_done1");
    cyc(1);
    ro_period = 8;
    wait_state(S_DONE, 40, "mm_done2");
    cyc(1);
    wait_state(S_DONE, 40, "mm_done3");
    cyc(1);
    en = 1'b0;
    chk("mm_last_count", 32'(out_count), 32'd2);
`ifdef RO_FREQ_MINMAX_EN
    chk("mm_max", 32'(out_max), 32'd4);
    chk("mm_min", 32'(out_min), 32'd2);
`else
    chk("mm_max", 32'(out_max), 32'd0);
    chk("mm_min", 32'(out_min), 32'd0);
`endif
    cyc(5);

    // narrow counter saturates over a 32-cycle window
    ro_period = 4;
    cyc(10);
    en2 = 1'b1;
    k = 0;
    while (!out_valid2 && k < 100) begin cyc(1); k++; end
    if (!out_valid2) fail_now("sat_result");
    chk("sat_count", 32'(out_count2), 32'd3);
    chk("sat_flag",  32'(out_sat2),   32'd1);
    en2 = 1'b0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
